bin2gray_counter: RTL and testbench

Synchronous up/down counter that keeps its state in binary and presents a registered, glitch-free Gray-coded copy alongside it. It is the encoding-side partner of the team's combinational Gray-to-binary converter. Its main use is generating pointers that cross clock domains, such as async-FIFO write and read pointers. The far domain synchronises `gray` and decodes it back to binary with the existing converter.

---
 rtl/bin2gray_counter.sv | 52 +++++
 tb/tb_bin2gray_counter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/bin2gray_counter.sv
// Up/down counter with a binary state register and a separately registered
// Gray-coded copy, intended for clock-domain-crossing pointers.
module bin2gray_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] load_bin,
  output logic [W-1:0] bin,
  output logic [W-1:0] gray,
  output logic         wrap
);

  logic [W-1:0] next_bin;
  logic         next_wrap;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned and no latch is inferred.
    next_bin  = bin;
    next_wrap = 1'b0;
    if (load) begin
      next_bin = load_bin;
    end else if (en) begin
      if (up) begin
        next_bin  = bin + W'(1);
        next_wrap = &bin;
      end else begin
        next_bin  = bin - W'(1);
        next_wrap = ~|bin;
      end
    end
  end

  // gray is encoded from next_bin and registered, so the far domain only ever
  // samples flop outputs and never sees a combinational glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin  <= '0;
      gray <= '0;
      wrap <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all three registers update together from pre-edge values.
      bin  <= next_bin;
      gray <= next_bin ^ (next_bin >> 1);
      wrap <= next_wrap;
    end
  end

endmodule

// File: tb/tb_bin2gray_counter.sv
// Directed and random self-checking bench for bin2gray_counter at W=4.
module tb_bin2gray_counter;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] load_bin;
  logic [W-1:0] bin;
  logic [W-1:0] gray;
  logic         wrap;

  int vectors    = 0;
  int miscompares = 0;

  bin2gray_counter #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_bin (load_bin),
    .bin      (bin),
    .gray     (gray),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Advance one rising edge, return at the falling edge for sampling.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic [W-1:0] b, input logic [W-1:0] g,
                            input logic w);
    check({tag, ".bin"},  16'(bin),  16'(b));
    check({tag, ".gray"}, 16'(gray), 16'(g));
    check({tag, ".wrap"}, 16'(wrap), 16'(w));
  endtask

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    for (int i = 0; i < W; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  logic [W-1:0] up_gray [0:16];
  logic [W-1:0] model;
  logic [W-1:0] prev_gray;

  initial begin
    up_gray = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    rst_n = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; load_bin = '0;
    @(negedge clk);
    expect_out("reset", 4'h0, 4'h0, 1'b0);
    rst_n = 1'b1;

    // Count up through the wrap.
    en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      expect_out($sformatf("up%0d", k), 4'(k), up_gray[k], k == 16);
    end

    // Count down from reset through the wrap.
    rst_n = 1'b0; #1; rst_n = 1'b1;
    expect_out("rst2", 4'h0, 4'h0, 1'b0);
    up = 1'b0;
    step(); expect_out("dn1", 4'hF, 4'h8, 1'b1);
    step(); expect_out("dn2", 4'hE, 4'h9, 1'b0);
    step(); expect_out("dn3", 4'hD, 4'hB, 1'b0);

    // Load wins over enable.
    load = 1'b1; load_bin = 4'hA;
    step(); expect_out("ld_a", 4'hA, 4'hF, 1'b0);
    load = 1'b0; up = 1'b1;
    step(); expect_out("ld_inc", 4'hB, 4'hE, 1'b0);

    // Loading the wrap boundary values must not raise wrap.
    load = 1'b1; load_bin = 4'hF;
    step(); expect_out("ld_f", 4'hF, 4'h8, 1'b0);
    load_bin = 4'h0;
    step(); expect_out("ld_0", 4'h0, 4'h0, 1'b0);

    // Hold, then direction changes.
    load_bin = 4'h5;
    step(); expect_out("ld_5", 4'h5, 4'h7, 1'b0);
    load = 1'b0; en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      up = k[0];
      step(); expect_out($sformatf("hold%0d", k), 4'h5, 4'h7, 1'b0);
    end
    en = 1'b1;
    up = 1'b1; step(); expect_out("dir_u", 4'h6, 4'h5, 1'b0);
    up = 1'b0; step(); expect_out("dir_d", 4'h5, 4'h7, 1'b0);
    up = 1'b1; step(); expect_out("dir_u2", 4'h6, 4'h5, 1'b0);

    // Async reset while a wrap pulse is pending.
    load = 1'b1; load_bin = 4'hF;
    step();
    load = 1'b0;
    step(); expect_out("pre_wrap", 4'h0, 4'h0, 1'b1);
    #2 rst_n = 1'b0; #1;
    expect_out("rst_wrap", 4'h0, 4'h0, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // Async reset mid-count at bin=C.
    load = 1'b1; load_bin = 4'hC;
    step(); expect_out("ld_c", 4'hC, 4'hA, 1'b0);
    load = 1'b0; en = 1'b0;
    #2 rst_n = 1'b0; #1;
    expect_out("rst_mid", 4'h0, 4'h0, 1'b0);
    @(negedge clk); rst_n = 1'b1; en = 1'b1; up = 1'b1;
    step(); expect_out("post_rst", 4'h1, 4'h1, 1'b0);

    // Random en/up: one-bit Gray changes and consistency with a model.
    model = 4'h1;
    prev_gray = gray;
    for (int k = 0; k < 1000; k++) begin
      en = 1'($urandom_range(0, 1));
      up = 1'($urandom_range(0, 1));
      if (en) model = up ? model + 4'h1 : model - 4'h1;
      step();
      check("rnd.bin", 16'(bin), 16'(model));
      check("rnd.gray", 16'(gray), 16'(model ^ (model >> 1)));
      check("rnd.g2b", 16'(gray2bin(gray)), 16'(bin));
      if (gray != prev_gray) check("rnd.onebit", 16'($countones(gray ^ prev_gray)), 16'd1);
      prev_gray = gray;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
